// File: rtl/filter_pkg.sv
// Shared constants for the filter datapath: default widths, multiplier latency
// limits and signed saturation bounds.
package filter_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int W_DEF        = 16;
  localparam int MULT_LAT_MIN = 1;
  localparam int MULT_LAT_MAX = 4;

  // Largest value representable in a w-bit two's-complement word.
  function automatic longint sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Round-robin picker: grants the first set request after ptr_i, wrapping
// modulo N, and reports the winner as one-hot and as an index.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] idx_o
);

  logic found_s;

  // Scan the N candidates starting just after the pointer.
  always_comb begin
    int j;
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found_s && req_i[j]) begin
        found_s  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among N_REQ
// requesters. Define MULT_ARB_SAT_EN for saturating results and the res_sat port.
module mult_arbiter
  import filter_pkg::*;
#(
  parameter int  N_REQ    = N_REQ_DEF,
  parameter int  W        = W_DEF,
  parameter int  MULT_LAT = 1,
  localparam int ID_W     = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               res_valid,
  output logic [ID_W-1:0]    res_id,
  output logic [W-1:0]       res_data,
`ifdef MULT_ARB_SAT_EN
  output logic               res_sat,
`endif
  output logic               busy
);

  logic [N_REQ-1:0]     gnt_s;
  logic [ID_W-1:0]      pick_idx_s;
  logic                 xfer_s;
  logic [ID_W-1:0]      lg_q, lg_d;
  logic signed [W-1:0]  a_sel_s, b_sel_s;
  logic [W-1:0]         prod_s;
  logic [MULT_LAT-1:0]  vld_q, vld_d;
  logic [ID_W-1:0]      id_q  [MULT_LAT];
  logic [W-1:0]         dat_q [MULT_LAT];
  logic                 busy_q;

  rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
    .req_i (req_valid),
    .ptr_i (lg_q),
    .gnt_o (gnt_s),
    .idx_o (pick_idx_s)
  );

  // Grants are suppressed while reset is held.
  always_comb begin
    if (rst_n) begin
      req_ready = gnt_s;
    end else begin
      req_ready = '0;
    end
  end

  assign xfer_s  = |(req_valid & req_ready);
  assign a_sel_s = req_a[int'(pick_idx_s)*W +: W];
  assign b_sel_s = req_b[int'(pick_idx_s)*W +: W];

`ifdef MULT_ARB_SAT_EN
  localparam logic signed [2*W-1:0] SAT_HI = (2*W)'(sat_hi(W));
  localparam logic signed [2*W-1:0] SAT_LO = (2*W)'(sat_lo(W));

  logic signed [2*W-1:0] prod_full_s;
  logic                  sat_s;
  logic [MULT_LAT-1:0]   sat_q;

  assign prod_full_s = a_sel_s * b_sel_s;

  // Clamp the full-width product into the W-bit signed range.
  always_comb begin
    if (prod_full_s > SAT_HI) begin
      prod_s = SAT_HI[W-1:0];
      sat_s  = 1'b1;
    end else if (prod_full_s < SAT_LO) begin
      prod_s = SAT_LO[W-1:0];
      sat_s  = 1'b1;
    end else begin
      prod_s = prod_full_s[W-1:0];
      sat_s  = 1'b0;
    end
  end

  // Saturation flags travel alongside the data stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= '0;
    end else begin
      sat_q <= MULT_LAT'({sat_q, sat_s});
    end
  end

  assign res_sat = sat_q[MULT_LAT-1];
`else
  // A W-bit context keeps only the low W bits of the product (wrap-around).
  assign prod_s = a_sel_s * b_sel_s;
`endif

  // Last-grant pointer follows each transfer.
  always_comb begin
    if (xfer_s) begin
      lg_d = pick_idx_s;
    end else begin
      lg_d = lg_q;
    end
  end

  // Pointer register; reset value makes requester 0 win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lg_q <= ID_W'(N_REQ - 1);
    end else begin
      lg_q <= lg_d;
    end
  end

  // Stage valids shift in the transfer strobe; no stall, no backpressure.
  always_comb begin
    vld_d = MULT_LAT'({vld_q, xfer_s});
  end

  // Multiply pipeline; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < MULT_LAT; i++) begin
        id_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      busy_q   <= |vld_d;
      id_q[0]  <= pick_idx_s;
      dat_q[0] <= prod_s;
      for (int i = 1; i < MULT_LAT; i++) begin
        id_q[i]  <= id_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign res_valid = vld_q[MULT_LAT-1];
  assign res_id    = id_q[MULT_LAT-1];
  assign res_data  = dat_q[MULT_LAT-1];
  assign busy      = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: a MULT_LAT=1 instance checked against a
// round-robin model and result scoreboard, plus a MULT_LAT=3 instance for reset.
module tb_mult_arbiter;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
    logic        sat;
  } exp_t;

  logic        clk;
  logic        rst_n, rst3_n;
  logic [3:0]  v1, ready1, v3, ready3;
  logic [63:0] a1, b1, a3, b3;
  logic        rv1, rv3, busy1, busy3;
  logic [1:0]  id1, id3;
  logic [15:0] d1, d3;
`ifdef MULT_ARB_SAT_EN
  logic        sat1, sat3;
`endif

  int   total = 0;
  int   bad   = 0;
  int   m_lg  = 3;
  int   opa [4];
  int   opb [4];
  exp_t sb [$];

  mult_arbiter #(.N_REQ(4), .W(16), .MULT_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_a(a1), .req_b(b1),
    .req_ready(ready1), .res_valid(rv1), .res_id(id1), .res_data(d1),
`ifdef MULT_ARB_SAT_EN
    .res_sat(sat1),
`endif
    .busy(busy1)
  );

  mult_arbiter #(.N_REQ(4), .W(16), .MULT_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .req_valid(v3), .req_a(a3), .req_b(b3),
    .req_ready(ready3), .res_valid(rv3), .res_id(id3), .res_data(d3),
`ifdef MULT_ARB_SAT_EN
    .res_sat(sat3),
`endif
    .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rr_model(input logic [3:0] v, input int lg);
    for (int k = 1; k <= 4; k++) begin
      if (v[(lg + k) % 4]) return 4'b0001 << ((lg + k) % 4);
    end
    return 4'b0000;
  endfunction

  function automatic exp_t exp_res(input int id, input int a, input int b);
    exp_t   e;
    longint p;
    p      = longint'(a) * longint'(b);
    e.id   = 2'(id);
    e.data = p[15:0];
    e.sat  = 1'b0;
`ifdef MULT_ARB_SAT_EN
    if (p > 64'sd32767) begin
      e.data = 16'h7FFF;
      e.sat  = 1'b1;
    end else if (p < -64'sd32768) begin
      e.data = 16'h8000;
      e.sat  = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic set_op(input int i, input int a, input int b);
    opa[i]         = a;
    opb[i]         = b;
    a1[i*16 +: 16] = 16'(a);
    b1[i*16 +: 16] = 16'(b);
  endtask

  task automatic set_op3(input int i, input int a, input int b);
    a3[i*16 +: 16] = 16'(a);
    b3[i*16 +: 16] = 16'(b);
  endtask

  // One clock: check results and grants of u_dut at the negedge, then advance.
  task automatic tick();
    logic [3:0] g;
    exp_t       e;
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      m_lg = 3;
      check("rdy_in_reset", 32'(ready1), 32'd0);
    end else begin
      if (rv1) begin
        if (sb.size() == 0) begin
          check("res_spurious", 32'(rv1), 32'd0);
        end else begin
          e = sb.pop_front();
          check("res_id", 32'(id1), 32'(e.id));
          check("res_data", 32'(d1), 32'(e.data));
`ifdef MULT_ARB_SAT_EN
          check("res_sat", 32'(sat1), 32'(e.sat));
`endif
        end
      end
      g = rr_model(v1, m_lg);
      check("grant", 32'(ready1), 32'(g));
      for (int j = 0; j < 4; j++) begin
        if (g[j]) begin
          sb.push_back(exp_res(j, opa[j], opb[j]));
          m_lg = j;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_g2 [5];
  logic [3:0] exp_g3 [6];

  initial begin
    exp_g2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_g3 = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
    rst_n = 1'b0; rst3_n = 1'b0;
    v1 = 4'b0000; v3 = 4'b0000;
    a1 = 64'd0; b1 = 64'd0; a3 = 64'd0; b3 = 64'd0;
    for (int i = 0; i < 4; i++) set_op(i, 0, 0);

    // Reset values, with requests pending
    v1 = 4'b1111;
    tick();
    tick();
    check("rst_res_valid", 32'(rv1), 32'd0);
    check("rst_res_id", 32'(id1), 32'd0);
    check("rst_res_data", 32'(d1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    v1 = 4'b0000;
    rst_n = 1'b1; rst3_n = 1'b1;
    tick();

    // Single requester 2: 3 * -6
    set_op(2, 3, -6);
    v1 = 4'b0100;
    #1;
    check("t1_ready", 32'(ready1), 32'h4);
    tick();
    v1 = 4'b0000;
    check("t1_res_valid", 32'(rv1), 32'd1);
    check("t1_res_id", 32'(id1), 32'd2);
    check("t1_res_data", 32'(d1), 32'hFFEE);
    check("t1_busy_on", 32'(busy1), 32'd1);
    tick();
    check("t1_busy_off", 32'(busy1), 32'd0);
    check("t1_res_off", 32'(rv1), 32'd0);

    // All four valid from reset: 0,1,2,3,0 and back-to-back results
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, i + 1, 10 * i - 7);
    v1 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t2_ready", 32'(ready1), 32'(exp_g2[k]));
      tick();
      check("t2_b2b_valid", 32'(rv1), 32'd1);
    end
    v1 = 4'b0000;
    tick();
    tick();

    // Requesters 0 and 2 only: strict alternation, 1 and 3 never granted
    set_op(0, 7, 9);
    set_op(2, -11, 13);
    v1 = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t3_ready", 32'(ready1), 32'(exp_g3[k]));
      tick();
    end
    v1 = 4'b0000;
    tick();
    tick();

    // Truncation / saturation corners through requester 1
    set_op(1, 300, 300);
    v1 = 4'b0010;
    tick();
`ifdef MULT_ARB_SAT_EN
    check("t4_300x300", 32'(d1), 32'h7FFF);
    check("t4_300x300_sat", 32'(sat1), 32'd1);
`else
    check("t4_300x300", 32'(d1), 32'd24464);
`endif
    set_op(1, -200, 200);
    tick();
`ifdef MULT_ARB_SAT_EN
    check("t4_m200x200", 32'(d1), 32'h8000);
    check("t4_m200x200_sat", 32'(sat1), 32'd1);
`else
    check("t4_m200x200", 32'(d1), 32'd25536);
`endif
    set_op(1, 100, -5);
    tick();
    check("t4_100xm5", 32'(d1), 32'hFE0C);
`ifdef MULT_ARB_SAT_EN
    check("t4_100xm5_sat", 32'(sat1), 32'd0);
`endif
    v1 = 4'b0000;
    tick();
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    // MULT_LAT=3: reset while products are in flight
    set_op3(0, 2, 3);
    set_op3(1, 4, 5);
    set_op3(2, 6, 7);
    v3 = 4'b0111;
    tick();
    tick();
    check("l3_busy_inflight", 32'(busy3), 32'd1);
    check("l3_no_res_yet", 32'(rv3), 32'd0);
    rst3_n = 1'b0;
    #1;
    check("l3_ready_in_reset", 32'(ready3), 32'd0);
    check("l3_busy_reset", 32'(busy3), 32'd0);
    v3 = 4'b0000;
    tick();
    rst3_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("l3_no_strobe", 32'(rv3), 32'd0);
      check("l3_idle_busy", 32'(busy3), 32'd0);
    end
    set_op3(0, 5, -9);
    v3 = 4'b1111;
    #1;
    check("l3_first_grant", 32'(ready3), 32'h1);
    tick();
    v3 = 4'b0000;
    check("l3_busy_new", 32'(busy3), 32'd1);
    check("l3_lat_c1", 32'(rv3), 32'd0);
    tick();
    check("l3_lat_c2", 32'(rv3), 32'd0);
    tick();
    check("l3_lat_c3", 32'(rv3), 32'd1);
    check("l3_res_id", 32'(id3), 32'd0);
    check("l3_res_data", 32'(d3), 32'hFFD3);
    tick();
    check("l3_single_strobe", 32'(rv3), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
